// File: rtl/backend_pkg.sv
// Shared constants and types for the analog-backend control block.
// Frame layout {resetb1, gainA1[2:0], resetb2, gainA2[1:0], resetbvco1, resetbvco2}.
package backend_pkg;

    localparam int FRAME_LEN = 9;

    localparam int RB1_POS  = 8;
    localparam int GA1_MSB  = 7;
    localparam int GA1_LSB  = 5;
    localparam int RB2_POS  = 4;
    localparam int GA2_MSB  = 3;
    localparam int GA2_LSB  = 2;
    localparam int RBV1_POS = 1;
    localparam int RBV2_POS = 0;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        APPLY
    } state_e;

endpackage

// File: rtl/vco_edge_counter.sv
// Synchronizes a VCO clock, detects its rising edges and counts them with
// saturation; the count clears on i_clr and is held at zero while i_hold is set.
module vco_edge_counter
    import backend_pkg::*;
#(
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_sig,
    input  logic             i_clr,
    input  logic             i_hold,
    output logic [CNT_W-1:0] o_cnt
);

    logic [2:0]       sync_q, sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rise;

    assign rise = sync_q[1] & ~sync_q[2];

    always_comb begin
        sync_d = {sync_q[1:0], i_sig};
        cnt_d  = cnt_q;
        if (i_hold || i_clr) begin
            cnt_d = '0;
        end else if (rise && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            cnt_q  <= '0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
        end
    end

    assign o_cnt = cnt_q;

endmodule

// File: rtl/backend_ctrl.sv
// Serial-configured amplifier/VCO control with an optional VCO frequency
// comparator, built only when BACKEND_VCO_CMP_EN is defined.
module backend_ctrl
    import backend_pkg::*;
#(
    parameter int WINDOW  = 256,
    parameter int CNT_W   = 10,
    parameter int TIMEOUT = 64
) (
    input  logic       i_clk,
    input  logic       i_resetbAll,
    input  logic       i_sclk,
    input  logic       i_sdin,
    input  logic       i_clk_vco1,
    input  logic       i_clk_vco2,
    output logic       o_ready,
    output logic       o_vco1_fast,
    output logic       o_resetb1,
    output logic [2:0] o_gainA1,
    output logic       o_resetb2,
    output logic [1:0] o_gainA2,
    output logic       o_resetbvco1,
    output logic       o_resetbvco2
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic [2:0]           sclk_sync_q, sclk_sync_d;
    logic [1:0]           sdin_sync_q, sdin_sync_d;
    state_e               state_q, state_d;
    logic [FRAME_LEN-1:0] shreg_q, shreg_d;
    logic [FRAME_LEN-1:0] cfg_q, cfg_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [TW-1:0]        tmo_q, tmo_d;
    logic                 sclk_rise;
    logic                 sbit;

    // sdin shares the sclk delay so the sampled bit lines up with the edge
    assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign sbit      = sdin_sync_q[1];

    always_comb begin
        sclk_sync_d = {sclk_sync_q[1:0], i_sclk};
        sdin_sync_d = {sdin_sync_q[0], i_sdin};
        state_d     = state_q;
        shreg_d     = shreg_q;
        cfg_d       = cfg_q;
        bit_cnt_d   = bit_cnt_q;
        tmo_d       = tmo_q;
        unique case (state_q)
            IDLE: begin
                tmo_d = '0;
                if (sclk_rise) begin
                    shreg_d   = {shreg_q[FRAME_LEN-2:0], sbit};
                    bit_cnt_d = 4'd1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (sclk_rise) begin
                    shreg_d = {shreg_q[FRAME_LEN-2:0], sbit};
                    tmo_d   = '0;
                    if (bit_cnt_q == 4'(FRAME_LEN - 1)) begin
                        state_d = APPLY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    tmo_d   = '0;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            APPLY: begin
                cfg_d   = shreg_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_resetbAll) begin
        if (!i_resetbAll) begin
            sclk_sync_q <= '0;
            sdin_sync_q <= '0;
            state_q     <= IDLE;
            shreg_q     <= '0;
            cfg_q       <= '0;
            bit_cnt_q   <= '0;
            tmo_q       <= '0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            sdin_sync_q <= sdin_sync_d;
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cfg_q       <= cfg_d;
            bit_cnt_q   <= bit_cnt_d;
            tmo_q       <= tmo_d;
        end
    end

    assign o_ready      = (state_q == IDLE);
    assign o_resetb1    = cfg_q[RB1_POS];
    assign o_gainA1     = cfg_q[GA1_MSB:GA1_LSB];
    assign o_resetb2    = cfg_q[RB2_POS];
    assign o_gainA2     = cfg_q[GA2_MSB:GA2_LSB];
    assign o_resetbvco1 = cfg_q[RBV1_POS];
    assign o_resetbvco2 = cfg_q[RBV2_POS];

`ifdef BACKEND_VCO_CMP_EN
    localparam int WW = $clog2(WINDOW);

    logic [WW-1:0]    win_q, win_d;
    logic             fast_q, fast_d;
    logic             win_end;
    logic [CNT_W-1:0] cnt1, cnt2;

    assign win_end = (win_q == WW'(WINDOW - 1));

    vco_edge_counter #(.CNT_W(CNT_W)) u_cnt1 (
        .clk    (i_clk),
        .rst_n  (i_resetbAll),
        .i_sig  (i_clk_vco1),
        .i_clr  (win_end),
        .i_hold (~cfg_q[RBV1_POS]),
        .o_cnt  (cnt1)
    );

    vco_edge_counter #(.CNT_W(CNT_W)) u_cnt2 (
        .clk    (i_clk),
        .rst_n  (i_resetbAll),
        .i_sig  (i_clk_vco2),
        .i_clr  (win_end),
        .i_hold (~cfg_q[RBV2_POS]),
        .o_cnt  (cnt2)
    );

    always_comb begin
        win_d  = win_end ? '0 : win_q + 1'b1;
        fast_d = win_end ? (cnt1 > cnt2) : fast_q;
    end

    always_ff @(posedge i_clk or negedge i_resetbAll) begin
        if (!i_resetbAll) begin
            win_q  <= '0;
            fast_q <= 1'b0;
        end else begin
            win_q  <= win_d;
            fast_q <= fast_d;
        end
    end

    assign o_vco1_fast = fast_q;
`else
    logic vco_unused;

    assign vco_unused  = i_clk_vco1 ^ i_clk_vco2;
    assign o_vco1_fast = 1'b0;
`endif

endmodule

// File: tb/tb_backend_ctrl.sv
// Scoreboard bench for backend_ctrl: applied frames are compared whenever
// o_ready returns high; VCO comparison results are checked after full windows.
`timescale 1ns/1ps
module tb_backend_ctrl;

`ifdef BACKEND_VCO_CMP_EN
    localparam logic CMP_EN = 1'b1;
`else
    localparam logic CMP_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk = 1'b0;
    logic       sdin = 1'b0;
    logic       vco1 = 1'b0;
    logic       vco2r = 1'b0;
    logic       vco_same = 1'b0;
    logic       vco2;
    int         half1 = 20;
    int         half2 = 40;

    logic       o_ready, o_vco1_fast;
    logic       o_resetb1, o_resetb2;
    logic [2:0] o_gainA1;
    logic [1:0] o_gainA2;
    logic       o_resetbvco1, o_resetbvco2;
    logic [8:0] cfg_word;

    int         checks = 0;
    int         failures = 0;
    logic [8:0] exp_q[$];
    logic       rdy_prev = 1'b1;

    assign vco2 = vco_same ? vco1 : vco2r;
    assign cfg_word = {o_resetb1, o_gainA1, o_resetb2, o_gainA2,
                       o_resetbvco1, o_resetbvco2};

    backend_ctrl dut (
        .i_clk        (clk),
        .i_resetbAll  (rst_n),
        .i_sclk       (sclk),
        .i_sdin       (sdin),
        .i_clk_vco1   (vco1),
        .i_clk_vco2   (vco2),
        .o_ready      (o_ready),
        .o_vco1_fast  (o_vco1_fast),
        .o_resetb1    (o_resetb1),
        .o_gainA1     (o_gainA1),
        .o_resetb2    (o_resetb2),
        .o_gainA2     (o_gainA2),
        .o_resetbvco1 (o_resetbvco1),
        .o_resetbvco2 (o_resetbvco2)
    );

    always #5 clk = ~clk;
    always begin #(half1); vco1 = ~vco1; end
    always begin #(half2); vco2r = ~vco2r; end

    task automatic check(string name, logic [8:0] act, logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: every return of o_ready marks a finished (or discarded) frame
    always @(negedge clk) begin
        if (o_ready === 1'b1 && rdy_prev === 1'b0) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ready actual=%h expected=none",
                         cfg_word);
            end else begin
                check("frame_apply", cfg_word, exp_q.pop_front());
            end
        end
        rdy_prev = o_ready;
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(logic [8:0] f, int nb);
        for (int i = 8; i > 8 - nb; i--) begin
            sdin = f[i];
            sclk = 1'b0;
            tick(3);
            sclk = 1'b1;
            tick(3);
        end
    endtask

    task automatic send_frame(logic [8:0] f);
        exp_q.push_back(f);
        send_bits(f, 9);
        tick(6);
    endtask

    localparam logic [8:0] FR_A = 9'b1_101_1_10_11;
    localparam logic [8:0] FR_P = 9'b0_011_0_01_10;
    localparam logic [8:0] FR_B = 9'b0_011_1_01_11;
    localparam logic [8:0] FR_C = 9'b1_010_0_11_01;
    localparam logic [8:0] FR_D = 9'b1_111_1_00_10;
    localparam logic [8:0] FR_E = 9'b0_110_1_11_00;

    initial begin
        int budget;

        tick(5);
        check("rst_ready", 9'(o_ready), 9'd1);
        check("rst_cfg", cfg_word, 9'd0);
        check("rst_fast", 9'(o_vco1_fast), 9'd0);
        rst_n = 1'b1;
        tick(3);
        check("rel_ready", 9'(o_ready), 9'd1);
        check("rel_cfg", cfg_word, 9'd0);

        send_frame(FR_A);
        check("a_gain1", 9'(o_gainA1), 9'd5);
        check("a_gain2", 9'(o_gainA2), 9'd2);

        exp_q.push_back(FR_A);
        send_bits(FR_P, 5);
        tick(80);
        send_frame(FR_B);

        half1 = 20;
        half2 = 40;
        tick(600);
        check("vco_4v8", 9'(o_vco1_fast), 9'(CMP_EN));
        half1 = 40;
        half2 = 20;
        tick(600);
        check("vco_8v4", 9'(o_vco1_fast), 9'd0);
        half1 = 20;
        vco_same = 1'b1;
        tick(600);
        check("vco_equal", 9'(o_vco1_fast), 9'd0);
        vco_same = 1'b0;
        half2 = 40;
        tick(600);
        check("vco_4v8_again", 9'(o_vco1_fast), 9'(CMP_EN));

        send_frame(FR_C);
        tick(600);
        check("vco1_held", 9'(o_vco1_fast), 9'd0);
        send_frame(FR_D);
        tick(600);
        check("vco2_held", 9'(o_vco1_fast), 9'(CMP_EN));

        send_bits(FR_E, 4);
        exp_q.push_back(9'd0);
        rst_n = 1'b0;
        tick(2);
        check("midrst_ready", 9'(o_ready), 9'd1);
        check("midrst_fast", 9'(o_vco1_fast), 9'd0);
        rst_n = 1'b1;
        sclk = 1'b0;
        tick(3);
        send_frame(FR_E);

        budget = 200;
        while (exp_q.size() != 0 && budget > 0) begin
            tick(1);
            budget--;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
